// File: rtl/bus_pkg.sv
// Shared types and default region map for the single-master bus interconnect.
package bus_pkg;

  typedef logic [31:0] bus_addr_t;

  // Transaction states: wait for strobe, wait for slave, present response.
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } bus_state_e;

  // Default map: RAM owns the low 256 MiB, UART a 16-byte window.
  localparam bus_addr_t RAM_BASE  = 32'h0000_0000;
  localparam bus_addr_t RAM_MASK  = 32'hF000_0000;
  localparam bus_addr_t UART_BASE = 32'h1000_0000;
  localparam bus_addr_t UART_MASK = 32'hFFFF_FFF0;

endpackage

// File: rtl/bus_region_decoder.sv
// Combinational priority address decoder: the lowest-index matching region wins.
module bus_region_decoder #(
  parameter int unsigned NumSlaves = 2,
  parameter int unsigned AddrWidth = 32
) (
  input  logic [AddrWidth-1:0]                 addr_i,
  input  logic [NumSlaves-1:0][AddrWidth-1:0]  base_i,
  input  logic [NumSlaves-1:0][AddrWidth-1:0]  mask_i,
  output logic [NumSlaves-1:0]                 sel_o,
  output logic                                 hit_o
);

  // Scan from the highest index down so a lower-index match overwrites it.
  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    for (int k = int'(NumSlaves) - 1; k >= 0; k--) begin
      if ((addr_i & mask_i[k]) == base_i[k]) begin
        sel_o    = '0;
        sel_o[k] = 1'b1;
        hit_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// Single-master, N-slave memory-mapped interconnect with registered one-hot select,
// read-data mux and bus-error response for unmapped addresses.
// Optional watchdog: define BUS_TIMEOUT_EN to abort hung slave accesses with an error.
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int unsigned NumSlaves     = 2,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter logic [NumSlaves-1:0][AddrWidth-1:0] SlaveBase = {UART_BASE, RAM_BASE},
  parameter logic [NumSlaves-1:0][AddrWidth-1:0] SlaveMask = {UART_MASK, RAM_MASK},
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [AddrWidth-1:0]           addr_i,
  input  logic [DataWidth-1:0]           wdata_i,
  input  logic                           wr_i,
  input  logic                           strobe_i,
  output logic [DataWidth-1:0]           rdata_o,
  output logic                           ready_o,
  output logic                           err_o,
  output logic [NumSlaves-1:0]           s_sel_o,
  output logic [AddrWidth-1:0]           s_addr_o,
  output logic [DataWidth-1:0]           s_wdata_o,
  output logic                           s_wr_o,
  output logic                           s_strobe_o,
  input  logic [NumSlaves*DataWidth-1:0] s_rdata_i,
  input  logic [NumSlaves-1:0]           s_ready_i
);

  bus_state_e             state_q;
  logic [NumSlaves-1:0]   sel_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic                   wr_q;
  logic                   s_strobe_q;
  logic                   ready_q;
  logic                   err_q;
  logic [DataWidth-1:0]   rdata_q;

  logic [NumSlaves-1:0]   dec_sel;
  logic                   dec_hit;
  logic                   slave_ready;
  logic [DataWidth-1:0]   slave_rdata;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
  logic [CntWidth-1:0]    cnt_q;
`else
  logic                   unused_timeout;
  assign unused_timeout = ^TimeoutCycles;
`endif

  bus_region_decoder #(
    .NumSlaves (NumSlaves),
    .AddrWidth (AddrWidth)
  ) u_decoder (
    .addr_i (addr_i),
    .base_i (SlaveBase),
    .mask_i (SlaveMask),
    .sel_o  (dec_sel),
    .hit_o  (dec_hit)
  );

  // Only the selected slave's ready and read data are visible to the FSM.
  always_comb begin
    slave_ready = |(s_ready_i & sel_q);
    slave_rdata = '0;
    for (int k = 0; k < int'(NumSlaves); k++) begin
      if (sel_q[k]) begin
        slave_rdata = slave_rdata | s_rdata_i[k*DataWidth +: DataWidth];
      end
    end
  end

  // Transaction FSM with latched request and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      s_strobe_q <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      // Pulsed outputs default low each cycle.
      s_strobe_q <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (strobe_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            wr_q    <= wr_i;
            if (dec_hit) begin
              sel_q      <= dec_sel;
              s_strobe_q <= 1'b1;
`ifdef BUS_TIMEOUT_EN
              cnt_q      <= '0;
`endif
              state_q    <= StWait;
            end else begin
              // Unmapped: answer directly, no slave is touched.
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= StResp;
            end
          end
        end
        StWait: begin
          // Ready wins over an expiring watchdog in the same cycle.
          if (slave_ready) begin
            rdata_q <= slave_rdata;
            ready_q <= 1'b1;
            state_q <= StResp;
          end
`ifdef BUS_TIMEOUT_EN
          else if (cnt_q == CntWidth'(TimeoutCycles)) begin
            rdata_q <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + CntWidth'(1);
          end
`endif
        end
        StResp: begin
          sel_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rdata_o    = rdata_q;
  assign ready_o    = ready_q;
  assign err_o      = err_q;
  assign s_sel_o    = sel_q;
  assign s_addr_o   = addr_q;
  assign s_wdata_o  = wdata_q;
  assign s_wr_o     = wr_q;
  assign s_strobe_o = s_strobe_q;

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed self-checking bench for bus_interconnect with the default two-slave map.
// Honours BUS_TIMEOUT_EN for the hung-slave scenario.
module tb_bus_interconnect;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        wr_i;
  logic        strobe_i;
  logic [31:0] rdata_o;
  logic        ready_o;
  logic        err_o;
  logic [1:0]  s_sel_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic        s_wr_o;
  logic        s_strobe_o;
  logic [63:0] s_rdata_i;
  logic [1:0]  s_ready_i;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  bus_interconnect u_dut (
    .clk        (clk),
    .rst        (rst),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .wr_i       (wr_i),
    .strobe_i   (strobe_i),
    .rdata_o    (rdata_o),
    .ready_o    (ready_o),
    .err_o      (err_o),
    .s_sel_o    (s_sel_o),
    .s_addr_o   (s_addr_o),
    .s_wdata_o  (s_wdata_o),
    .s_wr_o     (s_wr_o),
    .s_strobe_o (s_strobe_o),
    .s_rdata_i  (s_rdata_i),
    .s_ready_i  (s_ready_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".rdata"},  64'(rdata_o),    64'h0);
    check({tag, ".ready"},  64'(ready_o),    64'h0);
    check({tag, ".err"},    64'(err_o),      64'h0);
    check({tag, ".sel"},    64'(s_sel_o),    64'h0);
    check({tag, ".addr"},   64'(s_addr_o),   64'h0);
    check({tag, ".wdata"},  64'(s_wdata_o),  64'h0);
    check({tag, ".wr"},     64'(s_wr_o),     64'h0);
    check({tag, ".strobe"}, 64'(s_strobe_o), 64'h0);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for cycle 0; returns positioned in cycle 1.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d);
    addr_i   = a;
    wr_i     = w;
    wdata_i  = d;
    strobe_i = 1'b1;
    step();
    strobe_i = 1'b0;
  endtask

  initial begin
    int n_ready;
    int n_stb;
    int first;
    logic err_at;

    rst       = 1'b1;
    addr_i    = '0;
    wdata_i   = '0;
    wr_i      = 1'b0;
    strobe_i  = 1'b0;
    s_rdata_i = '0;
    s_ready_i = '0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Zero-wait-state RAM read.
    issue(32'h0000_0040, 1'b0, 32'h0);
    check("rd0.strobe", 64'(s_strobe_o), 64'h1);
    check("rd0.sel", 64'(s_sel_o), 64'h1);
    check("rd0.addr", 64'(s_addr_o), 64'h40);
    check("rd0.ready_c1", 64'(ready_o), 64'h0);
    s_ready_i = 2'b01;
    s_rdata_i = {32'h0, 32'hDEAD_BEEF};
    step();
    s_ready_i = 2'b00;
    check("rd0.ready_c2", 64'(ready_o), 64'h1);
    check("rd0.err", 64'(err_o), 64'h0);
    check("rd0.rdata", 64'(rdata_o), 64'hDEAD_BEEF);
    check("rd0.strobe_c2", 64'(s_strobe_o), 64'h0);
    step();
    check("rd0.ready_c3", 64'(ready_o), 64'h0);
    check("rd0.sel_clr", 64'(s_sel_o), 64'h0);

    // UART write with three wait states.
    issue(32'h1000_0004, 1'b1, 32'h41);
    for (int c = 1; c <= 4; c++) begin
      check("wr.s_wr", 64'(s_wr_o), 64'h1);
      check("wr.s_wdata", 64'(s_wdata_o), 64'h41);
      check("wr.sel", 64'(s_sel_o), 64'h2);
      check("wr.ready_early", 64'(ready_o), 64'h0);
      check("wr.strobe", 64'(s_strobe_o), (c == 1) ? 64'h1 : 64'h0);
      if (c == 4) begin
        s_ready_i = 2'b10;
        s_rdata_i = {32'h77, 32'h0};
      end
      step();
    end
    s_ready_i = 2'b00;
    check("wr.ready_c5", 64'(ready_o), 64'h1);
    check("wr.err", 64'(err_o), 64'h0);
    step();

    // Unmapped read.
    issue(32'h2000_0000, 1'b0, 32'h0);
    check("unm.ready", 64'(ready_o), 64'h1);
    check("unm.err", 64'(err_o), 64'h1);
    check("unm.rdata", 64'(rdata_o), 64'h0);
    check("unm.strobe", 64'(s_strobe_o), 64'h0);
    check("unm.sel", 64'(s_sel_o), 64'h0);
    step();
    check("unm.ready_c2", 64'(ready_o), 64'h0);
    check("unm.strobe_c2", 64'(s_strobe_o), 64'h0);

    // Stray strobe during WAIT and ready from the unselected slave are ignored.
    n_ready = 0;
    n_stb   = 0;
    issue(32'h0000_0100, 1'b0, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      n_ready += int'(ready_o);
      n_stb   += int'(s_strobe_o);
      if (c == 1) begin
        check("ign.sel", 64'(s_sel_o), 64'h1);
        strobe_i  = 1'b1;
        addr_i    = 32'h1000_0000;
        s_ready_i = 2'b10;
        s_rdata_i = {32'hBAD, 32'h0};
      end else if (c == 2) begin
        strobe_i = 1'b0;
        check("ign.ready_c2", 64'(ready_o), 64'h0);
      end else if (c == 3) begin
        check("ign.ready_c3", 64'(ready_o), 64'h0);
        check("ign.sel_c3", 64'(s_sel_o), 64'h1);
        s_ready_i = 2'b01;
        s_rdata_i = {32'hBAD, 32'h1234_5678};
      end else if (c == 4) begin
        s_ready_i = 2'b00;
        check("ign.ready_c4", 64'(ready_o), 64'h1);
        check("ign.rdata", 64'(rdata_o), 64'h1234_5678);
      end
      step();
    end
    check("ign.n_ready", 64'(n_ready), 64'd1);
    check("ign.n_strobe", 64'(n_stb), 64'd1);

    // Hung slave: watchdog error or indefinite stall.
    first  = 0;
    err_at = 1'b0;
    issue(32'h0000_0200, 1'b0, 32'h0);
    for (int c = 1; c <= 100; c++) begin
      if (ready_o && first == 0) begin
        first  = c;
        err_at = err_o;
      end
      step();
    end
`ifdef BUS_TIMEOUT_EN
    check("hang.ready_cycle", 64'(first), 64'd18);
    check("hang.err", 64'(err_at), 64'h1);
`else
    check("hang.ready_cycle", 64'(first), 64'd0);
    check("hang.err", 64'(err_at), 64'h0);
`endif
    rst = 1'b1;
    #1;
    check("hang.rst_sel", 64'(s_sel_o), 64'h0);
    step();
    rst = 1'b0;
    step();

    // Asynchronous reset in WAIT aborts, then a fresh read completes.
    issue(32'h1000_0008, 1'b1, 32'h55);
    step();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("arst");
    #1;
    rst = 1'b0;
    n_ready = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_ready += int'(ready_o);
    end
    check("arst.no_ready", 64'(n_ready), 64'd0);
    issue(32'h0000_0080, 1'b0, 32'h0);
    check("post.sel", 64'(s_sel_o), 64'h1);
    s_ready_i = 2'b01;
    s_rdata_i = {32'h0, 32'hCAFE_F00D};
    step();
    s_ready_i = 2'b00;
    check("post.ready", 64'(ready_o), 64'h1);
    check("post.err", 64'(err_o), 64'h0);
    check("post.rdata", 64'(rdata_o), 64'hCAFE_F00D);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
